// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution with two internal line buffers.
// Pass-thru, signed filter and abs-filter modes; 3-cycle latency.
module conv3x3_stream #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int CH    = 3,
  parameter int CW    = 4,
  parameter int KW    = 4,
  parameter int SW    = 3
) (
  input  logic              CLK100MHZ,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [9*KW-1:0]   kernel,
  input  logic [SW-1:0]     shift,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [CH*CW-1:0]  in_data,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_eol,
  output logic [CH*CW-1:0]  out_data,
  output logic              frame_err
);

  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int PW   = CH * CW;
  localparam int SUMW = CW + KW + 4;
  localparam logic [XW-1:0] XMAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(IMG_H - 1);
  localparam logic signed [SUMW-1:0] CMAX = SUMW'((1 << CW) - 1);

  logic [XW-1:0]    x_q, x_d, xe;
  logic [YW-1:0]    y_q, y_d, ye;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             acc, row_end, last;
  logic [1:0]       mode_q;
  logic [9*KW-1:0]  kern_q;
  logic [SW-1:0]    shift_q;

  logic [PW-1:0]    lb0_q [IMG_W];
  logic [PW-1:0]    lb1_q [IMG_W];
  logic [PW-1:0]    win_q [3][3];

  logic             v1_q, sof1_q, eol1_q, bord1_q;
  logic             v2_q, sof2_q, eol2_q, bord2_q;
  logic             filt2_q, abs2_q;
  logic [SW-1:0]    shift2_q;
  logic [PW-1:0]    pix2_q;
  logic signed [SUMW-1:0] sum_d [CH];
  logic signed [SUMW-1:0] sum2_q [CH];
  logic             v3_q, sof3_q, eol3_q, bord3_q, filt3_q;
  logic [PW-1:0]    pix3_q;
  logic signed [SUMW-1:0] r_d [CH];
  logic signed [SUMW-1:0] r3_q [CH];
  logic [PW-1:0]    od;

  // SOF restarts the raster at (0,0) whatever the counters say
  always_comb begin
    xe      = in_sof ? '0 : x_q;
    ye      = in_sof ? '0 : y_q;
    acc     = in_valid & (in_sof | ~done_q);
    row_end = (xe == XMAX);
    last    = row_end && (ye == YMAX);
    x_d     = x_q;
    y_d     = y_q;
    done_d  = done_q;
    err_d   = err_q;
    if (acc) begin
      x_d    = row_end ? '0 : xe + 1'b1;
      y_d    = !row_end ? ye
             : (ye == YMAX) ? '0 : ye + 1'b1;
      done_d = last;
    end
    if (in_valid && in_sof)
      err_d = 1'b0;
    else if (in_valid && done_q)
      err_d = 1'b1;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mode_q  <= '0;
      kern_q  <= '0;
      shift_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      done_q <= done_d;
      err_q  <= err_d;
      if (in_valid && in_sof) begin
        mode_q  <= mode;
        kern_q  <= kernel;
        shift_q <= shift;
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (acc) begin
      lb1_q[xe] <= lb0_q[xe];
      lb0_q[xe] <= in_data;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb1_q[xe];
      win_q[1][2] <= lb0_q[xe];
      win_q[2][2] <= in_data;
    end
  end

  always_comb begin
    logic signed [SUMW-1:0] pe;
    logic signed [SUMW-1:0] ke;
    pe = '0;
    ke = '0;
    for (int c = 0; c < CH; c++) begin
      sum_d[c] = '0;
      for (int i = 0; i < 9; i++) begin
        pe = SUMW'(win_q[i/3][i%3][c*CW +: CW]);
        ke = SUMW'($signed(kern_q[i*KW +: KW]));
        sum_d[c] = sum_d[c] + pe * ke;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      r_d[c] = sum2_q[c] >>> shift2_q;
      if (abs2_q && r_d[c] < 0)
        r_d[c] = -r_d[c];
    end
  end

  always_comb begin
    od = '0;
    for (int c = 0; c < CH; c++) begin
      if (!filt3_q)
        od[c*CW +: CW] = pix3_q[c*CW +: CW];
      else if (bord3_q || r3_q[c] < 0)
        od[c*CW +: CW] = '0;
      else if (r3_q[c] > CMAX)
        od[c*CW +: CW] = CMAX[CW-1:0];
      else
        od[c*CW +: CW] = r3_q[c][CW-1:0];
    end
  end

  // Mode and shift travel with the pixel so a new SOF cannot retag it
  always_ff @(posedge CLK100MHZ) begin
    sof1_q   <= (xe == '0) && (ye == '0);
    eol1_q   <= row_end;
    bord1_q  <= (xe < XW'(2)) || (ye < YW'(2));
    sof2_q   <= sof1_q;
    eol2_q   <= eol1_q;
    bord2_q  <= bord1_q;
    filt2_q  <= (mode_q == 2'b01) || (mode_q == 2'b10);
    abs2_q   <= (mode_q == 2'b10);
    shift2_q <= shift_q;
    pix2_q   <= win_q[2][2];
    sum2_q   <= sum_d;
    sof3_q   <= sof2_q;
    eol3_q   <= eol2_q;
    bord3_q  <= bord2_q;
    filt3_q  <= filt2_q;
    pix3_q   <= pix2_q;
    r3_q     <= r_d;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_data  <= '0;
    end else begin
      v1_q      <= acc;
      v2_q      <= v1_q;
      v3_q      <= v2_q;
      out_valid <= v3_q;
      out_sof   <= v3_q & sof3_q;
      out_eol   <= v3_q & eol3_q;
      if (v3_q)
        out_data <= od;
    end
  end

  assign frame_err = err_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Scoreboard bench for conv3x3_stream on an 8x6 image.
// Expected pixels come from a direct window-sum model of each frame.
module tb_conv3x3_stream;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 12;

  localparam int K_IDX  = 0;
  localparam int K_F5   = 1;
  localparam int K_F15  = 2;
  localparam int K_EDGE = 3;
  localparam int K_RND  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode = '0;
  logic [35:0]   kernel = '0;
  logic [2:0]    shift = '0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [PW-1:0] in_data = '0;
  logic          out_valid, out_sof, out_eol;
  logic [PW-1:0] out_data;
  logic          frame_err;

  conv3x3_stream #(
    .IMG_W(W), .IMG_H(H), .CH(3), .CW(4), .KW(4), .SW(3)
  ) dut (
    .CLK100MHZ(clk),
    .rst_n(rst_n),
    .mode(mode),
    .kernel(kernel),
    .shift(shift),
    .in_valid(in_valid),
    .in_sof(in_sof),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_sof(out_sof),
    .out_eol(out_eol),
    .out_data(out_data),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic          sof;
    logic          eol;
    logic [PW-1:0] d;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int total = 0;
  int bad = 0;
  int nout = 0;
  int npush = 0;

  int m_mode, m_sh, mx, my;
  int m_k[9];
  int kset[9];
  bit mdone;
  logic [PW-1:0] img [H][W];

  function automatic logic [PW-1:0] ref_px(input int x, input int y);
    logic [PW-1:0] r;
    int s;
    r = img[y][x];
    if (m_mode == 1 || m_mode == 2) begin
      for (int c = 0; c < 3; c++) begin
        s = 0;
        if (x >= 2 && y >= 2) begin
          for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
              s += m_k[rr*3+cc] *
                   int'(img[y-2+rr][x-2+cc][c*4 +: 4]);
          s = s >>> m_sh;
          if (m_mode == 2 && s < 0) s = -s;
          if (s < 0) s = 0;
          if (s > 15) s = 15;
        end
        r[c*4 +: 4] = 4'(s);
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int ex);
    total++;
    if (act != ex) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, ex);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input bit sof, input logic [PW-1:0] d);
    exp_t e;
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    if (sof) begin
      mx = 0;
      my = 0;
      mdone = 1'b0;
    end
    if (sof || !mdone) begin
      img[my][mx] = d;
      e.cyc = cyc + 4;
      e.sof = (mx == 0 && my == 0);
      e.eol = (mx == W - 1);
      e.d   = ref_px(mx, my);
      q.push_back(e);
      npush++;
      if (mx == W - 1) begin
        mx = 0;
        if (my == H - 1) begin
          mdone = 1'b1;
          my = 0;
        end else my++;
      end else mx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // gap: 1 continuous, n one pixel every n cycles, 0 random
  task automatic frame(input int md, input int sh, input int kind,
                       input int gap, input int npix);
    logic [PW-1:0] d;
    logic [3:0] v;
    m_mode = md;
    m_sh   = sh;
    m_k    = kset;
    npush  = 0;
    nout   = 0;
    mode   = 2'(md);
    shift  = 3'(sh);
    for (int i = 0; i < 9; i++) kernel[i*4 +: 4] = 4'(kset[i]);
    for (int i = 0; i < npix; i++) begin
      if (i > 0) begin
        if (gap == 0) idle($urandom_range(2, 0));
        else idle(gap - 1);
      end
      v = 4'(i % 16);
      case (kind)
        K_IDX:   d = {v, v, v};
        K_F5:    d = 12'h555;
        K_F15:   d = 12'hFFF;
        K_EDGE:  d = ((i % W) < 4) ? 12'h000 : 12'hCCC;
        default: d = 12'($urandom);
      endcase
      send(i == 0, d);
      if (i == 0 || i == 20) begin
        mode   = 2'($urandom);
        kernel = 36'({$urandom, $urandom});
        shift  = 3'($urandom);
      end
    end
  endtask

  task automatic drain(input string nm, input int want);
    idle(8);
    chk(nm, nout, want);
    chk({nm, "_left"}, q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        nout++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: got data=%h cyc=%0d",
                   out_data, cyc);
        end else begin
          me = q.pop_front();
          if (me.cyc != cyc || me.sof != out_sof ||
              me.eol != out_eol || me.d != out_data) begin
            bad++;
            $display({"FAIL pixel: got cyc=%0d sof=%0b eol=%0b ",
                      "d=%h expected cyc=%0d sof=%0b eol=%0b d=%h"},
                     cyc, out_sof, out_eol, out_data,
                     me.cyc, me.sof, me.eol, me.d);
          end
        end
      end
      while (q.size() > 0 && q[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_out: got none expected d=%h cyc=%0d",
                 q[0].d, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    idle(3);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sof", int'(out_sof), 0);
    chk("rst_eol", int'(out_eol), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_err", int'(frame_err), 0);
    rst_n = 1'b1;
    idle(2);

    kset = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    frame(0, 0, K_IDX, 1, 48);
    drain("pass_cnt", 48);

    kset = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    frame(1, 0, K_F5, 1, 48);
    drain("ident_cnt", 48);

    kset = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    frame(1, 3, K_F15, 1, 48);
    drain("box_cnt", 48);

    kset = '{0, 0, 0, -1, 1, 0, 0, 0, 0};
    frame(2, 0, K_EDGE, 1, 48);
    drain("edge_abs_cnt", 48);
    frame(1, 0, K_EDGE, 1, 48);
    drain("edge_flt_cnt", 48);
    kset = '{0, 0, 0, 1, -1, 0, 0, 0, 0};
    frame(1, 0, K_EDGE, 1, 48);
    drain("edge_neg_cnt", 48);
    frame(2, 0, K_EDGE, 1, 48);
    drain("edge_nabs_cnt", 48);

    kset = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    frame(1, 3, K_RND, 3, 48);
    drain("gap_cnt", 48);

    kset = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    frame(0, 0, K_RND, 1, 50);
    drain("ovr_cnt", 48);
    chk("ovr_err_set", int'(frame_err), 1);
    frame(0, 0, K_RND, 1, 1);
    chk("ovr_err_clr", int'(frame_err), 0);
    idle(6);

    kset = '{1, -2, 1, 3, 0, -1, 2, 1, -3};
    frame(1, 1, K_RND, 1, 20);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_sof", int'(out_sof), 0);
    chk("mid_rst_eol", int'(out_eol), 0);
    chk("mid_rst_data", int'(out_data), 0);
    chk("mid_rst_err", int'(frame_err), 0);
    q.delete();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stale_valid", int'(out_valid), 0);
    end

    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 9; i++)
        kset[i] = int'($urandom_range(15, 0)) - 8;
      frame(int'($urandom_range(3, 0)), int'($urandom_range(7, 0)),
            K_RND, 0, 48);
      drain("rnd_cnt", 48);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
- Parametrised streaming 3x3 convolution engine; successor to the fixed kernel_ROM/ALU pair.
- Sits between the camera capture path and the frame-buffer write port of mem_controller.
- Keeps two line buffers internally, applies a per-frame latched kernel per colour channel, and supports pass-through, signed-filter and absolute-value (edge) modes.

Parameters:
- IMG_W, 320, pixels per line (>=3)
- IMG_H, 240, lines per frame (>=3)
- CH, 3, colour channels per pixel
- CW, 4, bits per channel
- KW, 4, bits per signed kernel coefficient
- SW, 3, width of right-shift (divisor) field

Ports:
- CLK100MHZ  in  1  system clock, all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- mode  in  2  00 pass-thru, 01 filter, 10 abs-filter, 11 treated as 00; latched at SOF
- kernel  in  9*KW  coefficients k0..k8, k0 in LSBs, raster order (k0 = top-left, k8 = bottom-right), signed two's complement; latched at SOF
- shift  in  SW  arithmetic right shift applied to sum; latched at SOF
- in_valid  in  1  input pixel qualifier
- in_sof  in  1  first pixel of frame; meaningful only with in_valid
- in_data  in  CH*CW  input pixel, channel 0 in LSBs
- out_valid  out  1  output pixel qualifier
- out_sof  out  1  first output pixel of frame
- out_eol  out  1  last pixel of a line
- out_data  out  CH*CW  output pixel
- frame_err  out  1  sticky overrun flag

Behaviour:
- Reset (rst_n=0 at edge): out_valid, out_sof, out_eol, out_data, frame_err = 0; x=y=0; latched mode=00, kernel=0, shift=0; pipeline valid bits cleared. Line buffer RAM contents are not cleared.
- Counters: x and y advance only on in_valid. in_valid & in_sof forces the pixel to (0,0) regardless of current count (mid-frame restart) and latches mode/kernel/shift in the same cycle. x wraps IMG_W-1 -> 0 with y+1.
- Overrun: a valid non-SOF pixel arriving after (IMG_W-1, IMG_H-1):
  - is dropped;
  - produces no output;
  - sets frame_err.
- frame_err clears only on the next in_sof or on reset.
- Window: on each accepted pixel, the 3x3 window shifts left.
  - New right column = {linebuf1[x], linebuf0[x], in_data} (top to bottom).
  - Then linebuf1[x] <= linebuf0[x] and linebuf0[x] <= in_data.
  - Window bottom-right = current input (x,y); centre = (x-1,y-1).
- Output rule: each accepted input pixel (x,y) yields exactly one output pixel at the same raster position.
  - out_sof = (x==0 && y==0).
  - out_eol = (x==IMG_W-1).
- Latency: out_valid is asserted exactly 3 cycles after the accepting in_valid edge. The pipeline is free-running, with valid tagged per stage; input gaps propagate as out_valid gaps. No backpressure.
- Pass-thru: out_data = in_data delayed 3 cycles; no border zeroing.
- Filter, per channel c:
  - S = sum_i k_i * p_i, p_i unsigned CW-bit.
  - S held at CW+KW+4 bits signed; no overflow possible.
  - R = S >>> shift (arithmetic).
  - Mode 10: R = |R|.
  - Clamp R to [0, 2^CW-1].
- Border: if x<2 or y<2, filter-mode output is 0 for all channels.
- Mode/kernel changes mid-frame have no effect until the next in_sof.
- Reset asserted mid-frame: in-flight pixels are discarded (no out_valid on the cycle after reset); the next frame needs in_sof.

Test Plan (IMG_W=8, IMG_H=6, CH=3, CW=4):
- Pass-thru: frame of 48 pixels, values = index mod 16 per channel, continuous in_valid -> 48 out_valid, each 3 cycles after its input; data equal; out_sof on pixel 0; out_eol on pixels 7,15,…,47.
- Identity filter: k4=1, others 0, shift=0, flat image all channels 5 -> output 0 for x<2 or y<2, else 5; 48 outputs.
- Box blur with clamp: all k=1, shift=3, flat 15 -> interior = 135>>3 = 16, clamped to 15.
- Abs-filter edge: k = {0,0,0,-1,1,0,0,0,0}, shift=0; left half 0, right half 12 (vertical edge between x=3 and x=4) -> filter window's centre-column-minus-left-column difference; response 12 at window position x=5, otherwise 0 in the interior. Mode 01 gives 12 there too. Repeat with coefficients swapped: mode 01 clamps −12 to 0, mode 10 gives 12.
- Gapped input + mid-frame kernel change: in_valid every 3rd cycle, kernel changed at pixel 20 -> out_valid pattern mirrors the input pattern delayed 3 cycles; the whole frame uses the original kernel.
- Overrun and restart: send 50 pixels without a new SOF -> pixels 49 and 50 produce no output; frame_err=1. Next in_sof -> frame_err=0. Then assert rst_n=0 mid-frame for 1 cycle -> all outputs 0 and no stale out_valid.
